// File: rtl/obi_line_adapter_if.sv
// OBI point-to-point bundles between obi_line_adapter and the single-port
// OBI SRAM slave.
//   obi_req_if : req, gnt, addr[31:0], we, be[3:0], wdata[31:0]
//     master modport drives the request fields and samples gnt.
//   obi_rsp_if : rvalid, rdata[31:0]
//     slave modport samples the response (used by the adapter),
//     master modport drives it (used by the memory side).
interface obi_req_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  modport master (output req, addr, we, be, wdata, input gnt);
  modport slave  (input req, addr, we, be, wdata, output gnt);
endinterface

interface obi_rsp_if;
  logic        rvalid;
  logic [31:0] rdata;

  modport slave  (input rvalid, rdata);
  modport master (output rvalid, rdata);
endinterface

// File: rtl/obi_line_adapter.sv
// obi_line_adapter: splits one LINE_WORDS x 32-bit line request into
// sequential single-word OBI transactions (one outstanding at a time) and
// returns a single line response.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   line_req_valid_i/ready_o           line request handshake
//   line_req_we_i/addr_i/wdata_i/be_i  line request payload (word i at slice i)
//   line_rsp_valid_o/ready_i           line response handshake
//   line_rsp_we_o/rdata_o              echoed we, assembled read data
//   req (obi_req_if.master)            OBI request channel
//   rsp (obi_rsp_if.slave)             OBI response channel
// Optional feature macro: OBI_LINE_SKIP_EMPTY_EN -- write words with be==0
// are not issued on OBI at all.
module obi_line_adapter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    line_req_valid_i,
  output logic                    line_req_ready_o,
  input  logic                    line_req_we_i,
  input  logic [31:0]             line_req_addr_i,
  input  logic [LINE_WORDS*32-1:0] line_req_wdata_i,
  input  logic [LINE_WORDS*4-1:0]  line_req_be_i,
  output logic                    line_rsp_valid_o,
  input  logic                    line_rsp_ready_i,
  output logic                    line_rsp_we_o,
  output logic [LINE_WORDS*32-1:0] line_rsp_rdata_o,
  obi_req_if.master               req,
  obi_rsp_if.slave                rsp
);

  localparam int unsigned IW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t                   r_state;
  logic [IW-1:0]            r_idx;
  logic                     r_we;
  logic [31:0]              r_base;
  logic [LINE_WORDS*32-1:0] r_wdata;
  logic [LINE_WORDS*4-1:0]  r_be;
  logic [LINE_WORDS*32-1:0] r_buf;
  logic                     r_ready;
  logic                     r_rsp_valid;
  logic                     r_req;
  logic [31:0]              r_addr;
  logic                     r_obi_we;
  logic [3:0]               r_obi_be;
  logic [31:0]              r_obi_wdata;

  // Per-word "must be issued" masks for the incoming request and the captured one.
  logic [LINE_WORDS-1:0] w_act_new;
  logic [LINE_WORDS-1:0] w_act_cur;

  always_comb begin
    w_act_new = '1;
    w_act_cur = '1;
`ifdef OBI_LINE_SKIP_EMPTY_EN
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      w_act_new[i] = !line_req_we_i || (line_req_be_i[4*i +: 4] != 4'h0);
      w_act_cur[i] = !r_we || (r_be[4*i +: 4] != 4'h0);
    end
`endif
  end

  // First word to issue: from 0 on acceptance, after r_idx when leaving WAIT.
  // Without skipping this reduces to index 0 / r_idx+1 / done at LINE_WORDS-1.
  logic          w_new_found;
  logic [IW-1:0] w_new_idx;
  logic          w_cur_found;
  logic [IW-1:0] w_cur_idx;

  always_comb begin
    w_new_found = 1'b0;
    w_new_idx   = '0;
    w_cur_found = 1'b0;
    w_cur_idx   = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      if (!w_new_found && w_act_new[i]) begin
        w_new_found = 1'b1;
        w_new_idx   = IW'(i);
      end
      if (!w_cur_found && (i > 32'(r_idx)) && w_act_cur[i]) begin
        w_cur_found = 1'b1;
        w_cur_idx   = IW'(i);
      end
    end
  end

  // Shared word-issue path for both IDLE (fresh request) and WAIT (next word).
  logic          w_in_idle;
  logic          w_adv;
  logic          w_found;
  logic [IW-1:0] w_sel_idx;
  logic [31:0]   w_sel_base;
  logic          w_sel_we;
  logic [3:0]    w_sel_be;
  logic [31:0]   w_sel_wdata;

  always_comb begin
    w_in_idle   = (r_state == IDLE);
    w_adv       = (w_in_idle && line_req_valid_i && r_ready) ||
                  ((r_state == WAIT) && rsp.rvalid);
    w_found     = w_in_idle ? w_new_found : w_cur_found;
    w_sel_idx   = w_in_idle ? w_new_idx : w_cur_idx;
    w_sel_base  = w_in_idle ? (line_req_addr_i & ALIGN_MASK) : r_base;
    w_sel_we    = w_in_idle ? line_req_we_i : r_we;
    w_sel_be    = w_in_idle ? line_req_be_i[4*w_sel_idx +: 4] : r_be[4*w_sel_idx +: 4];
    w_sel_wdata = w_in_idle ? line_req_wdata_i[32*w_sel_idx +: 32]
                            : r_wdata[32*w_sel_idx +: 32];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_we        <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_buf       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_obi_we    <= 1'b0;
      r_obi_be    <= '0;
      r_obi_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (line_req_valid_i && r_ready) begin
            r_we    <= line_req_we_i;
            r_base  <= line_req_addr_i & ALIGN_MASK;
            r_wdata <= line_req_wdata_i;
            r_be    <= line_req_be_i;
            r_buf   <= '0;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        REQ: begin
          if (req.gnt) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (rsp.rvalid && !r_we) r_buf[32*r_idx +: 32] <= rsp.rdata;
        end
        RSP: begin
          if (line_rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_adv) begin
        if (w_found) begin
          r_state     <= REQ;
          r_idx       <= w_sel_idx;
          r_req       <= 1'b1;
          r_addr      <= w_sel_base + (32'(w_sel_idx) << 2);
          r_obi_we    <= w_sel_we;
          r_obi_be    <= w_sel_we ? w_sel_be : 4'hF;
          r_obi_wdata <= w_sel_wdata;
        end else begin
          r_state     <= RSP;
          r_rsp_valid <= 1'b1;
        end
      end
    end
  end

  assign line_req_ready_o = r_ready;
  assign line_rsp_valid_o = r_rsp_valid;
  assign line_rsp_we_o    = r_we;
  assign line_rsp_rdata_o = r_buf;
  assign req.req          = r_req;
  assign req.addr         = r_addr;
  assign req.we           = r_obi_we;
  assign req.be           = r_obi_be;
  assign req.wdata        = r_obi_wdata;

endmodule

// File: tb/tb_obi_line_adapter.sv
module tb_obi_line_adapter;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid, we, rsp_ready;
  logic [31:0]     addr;
  logic [LW*32-1:0] wd;
  logic [LW*4-1:0]  be;
  logic            req_ready, rsp_valid, rsp_we;
  logic [LW*32-1:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  obi_req_if u_req ();
  obi_rsp_if u_rsp ();

  obi_line_adapter #(.LINE_WORDS(LW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .line_req_valid_i (valid),
    .line_req_ready_o (req_ready),
    .line_req_we_i    (we),
    .line_req_addr_i  (addr),
    .line_req_wdata_i (wd),
    .line_req_be_i    (be),
    .line_rsp_valid_o (rsp_valid),
    .line_rsp_ready_i (rsp_ready),
    .line_rsp_we_o    (rsp_we),
    .line_rsp_rdata_o (rsp_rdata),
    .req              (u_req),
    .rsp              (u_rsp)
  );

  always #5 clk = ~clk;

  // ---------------- OBI SRAM model (gnt same cycle, rvalid next cycle) -----
  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [3:0]  b;
    logic [31:0] d;
  } txn_t;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  txn_t        txq[$];

  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic        stray = 1'b0;
  logic [31:0] stray_data = '0;
  logic [31:0] stall_addr = '0;
  int          stall_n = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] p_a, p_d, mw;
  logic [3:0]  p_b;
  logic        p_w;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h3C5A_96E1);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h3C5A_96E1);
  endfunction

  assign u_req.gnt    = u_req.req && !(stall_n > 0 && u_req.addr == stall_addr);
  assign u_rsp.rvalid = rv_q | stray;
  assign u_rsp.rdata  = stray ? stray_data : rd_q;

  always @(posedge clk) begin
    if (prev_stall && rst_n &&
        !(u_req.req && u_req.addr == p_a && u_req.be == p_b &&
          u_req.wdata == p_d && u_req.we == p_w))
      stab_err++;
    prev_stall <= u_req.req && !u_req.gnt;
    p_a <= u_req.addr; p_b <= u_req.be; p_d <= u_req.wdata; p_w <= u_req.we;
    if (u_req.req && !u_req.gnt) stall_n <= stall_n - 1;
    rv_q <= u_req.req && u_req.gnt;
    if (u_req.req && u_req.gnt) begin
      txq.push_back('{u_req.addr, u_req.we, u_req.be, u_req.wdata});
      if (u_req.we) begin
        mw = mem_rd(u_req.addr);
        for (int b = 0; b < 4; b++)
          if (u_req.be[b]) mw[8*b +: 8] = u_req.wdata[8*b +: 8];
        mem[u_req.addr] = mw;
        rd_q <= $urandom;
      end else begin
        rd_q <= mem_rd(u_req.addr);
      end
    end
  end

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // One full line transaction checked against the reference model:
  // word j of the line lives at base+4j; a word is issued unless it is an
  // empty write word and skipping is enabled; each issued word costs two
  // cycles plus any withheld-gnt cycles, and the response rises one cycle later.
  task automatic run_line(input logic we_i, input logic [31:0] a,
                          input logic [LW*32-1:0] wd_i, input logic [LW*4-1:0] be_i,
                          input int hold, input int sw, input int sc);
    logic [31:0]      base, aj, wj, nv;
    logic [3:0]       bj;
    logic [LW*32-1:0] exp_rd;
    txn_t             exp_q[$];
    int               exp_lat, cyc, n;
    bit               act;
    base    = a & ~32'(LW*4 - 1);
    exp_rd  = '0;
    exp_lat = 1;
    for (int j = 0; j < LW; j++) begin
      bj  = be_i[4*j +: 4];
      wj  = wd_i[32*j +: 32];
      aj  = base + 32'(4*j);
      act = 1'b1;
`ifdef OBI_LINE_SKIP_EMPTY_EN
      if (we_i && bj == 4'h0) act = 1'b0;
`endif
      if (!we_i) exp_rd[32*j +: 32] = ref_rd(aj);
      if (act) begin
        exp_q.push_back('{aj, we_i, we_i ? bj : 4'hF, wj});
        exp_lat += 2;
        if (j == sw) exp_lat += sc;
      end
      if (we_i) begin
        nv = ref_rd(aj);
        for (int b = 0; b < 4; b++) if (bj[b]) nv[8*b +: 8] = wj[8*b +: 8];
        ref_mem[aj] = nv;
      end
    end
    if (sw >= 0) begin
      stall_addr = base + 32'(4*sw);
      stall_n    = sc;
    end
    txq.delete();

    @(negedge clk);
    valid = 1'b1; we = we_i; addr = a; wd = wd_i; be = be_i;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rsp_valid && cyc < 200);
    chk("rsp_latency", cyc, exp_lat);
    chk("rsp_we", rsp_we, we_i);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_rsp_ready", req_ready, 1);
    chk("obi_count", txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      chk("obi_addr", txq[i].a, exp_q[i].a);
      chk("obi_we", txq[i].w, exp_q[i].w);
      chk("obi_be", txq[i].b, exp_q[i].b);
      chk("obi_wdata", txq[i].d, exp_q[i].d);
    end
    chk("obi_stable", stab_err, 0);
    stall_n = 0;
  endtask

  function automatic logic [LW*32-1:0] rnd_data();
    logic [LW*32-1:0] d;
    for (int j = 0; j < LW; j++) d[32*j +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [LW*4-1:0] rnd_be();
    logic [LW*4-1:0] b;
    for (int j = 0; j < LW; j++)
      b[4*j +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; valid = 1'b0; we = 1'b0; addr = '0; wd = '0; be = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_obi_req", u_req.req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // Aligned read of A0..A3 from an unaligned request address.
    for (int j = 0; j < 4; j++) set_word(32'h100 + 32'(4*j), 32'hA0 + 32'(j));
    run_line(1'b0, 32'h104, rnd_data(), '0, 0, -1, 0);

    // Write with word 2 disabled, then read back.
    run_line(1'b1, 32'h200, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
             16'hF0FF, 0, -1, 0);
    run_line(1'b0, 32'h200, rnd_data(), '0, 0, -1, 0);

    // Response backpressure.
    run_line(1'b0, 32'h200, rnd_data(), '0, 5, -1, 0);

    // gnt withheld 3 cycles on word 1.
    run_line(1'b1, 32'h340, rnd_data(), 16'hFFFF, 0, 1, 3);
    run_line(1'b0, 32'h340, rnd_data(), '0, 0, 1, 3);

    // Reset while waiting on word 2's response.
    @(negedge clk);
    valid = 1'b1; we = 1'b0; addr = 32'h300; wd = rnd_data(); be = '0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_obi_req", u_req.req, 0);
    chk("mid_rst_obi_addr", u_req.addr, 0);
    chk("mid_rst_obi_we", u_req.we, 0);
    chk("mid_rst_obi_be", u_req.be, 0);
    chk("mid_rst_obi_wdata", u_req.wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b1; stray_data = 32'hBAD0BAD0;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_ready", req_ready, 1);
    chk("stray_valid", rsp_valid, 0);
    chk("stray_obi_req", u_req.req, 0);
    chk("stray_rdata", rsp_rdata, 0);
    run_line(1'b0, 32'h300, rnd_data(), '0, 0, -1, 0);

    // Address wrap at the top of the address space.
    run_line(1'b0, 32'hFFFF_FFF0, rnd_data(), '0, 0, -1, 0);

    // Write with every byte enable clear.
    run_line(1'b1, 32'h400, rnd_data(), '0, 0, -1, 0);

    // Randomized lines.
    for (int t = 0; t < 16; t++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 255)) << 2;
      run_line(1'($urandom_range(0, 1)), ra, rnd_data(), rnd_be(),
               $urandom_range(0, 3), $urandom_range(0, 4) - 1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/obi_line_adapter.md
Name: obi_line_adapter

Overview:
- Upstream master stage for the single-port OBI SRAM slave.
- Accepts one multi-word line request (read or write) from the GPU memory side.
- Splits the line into sequential single-word OBI transactions and returns one line response.
- Keeps at most one OBI transaction outstanding, matching the slave's gnt-then-rvalid protocol.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, >=1.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- line_req_valid_i  input  1  line request valid
- line_req_ready_o  output  1  adapter can accept a request
- line_req_we_i  input  1  1=write line, 0=read line
- line_req_addr_i  input  32  byte address of the line; low $clog2(LINE_WORDS*4) bits ignored
- line_req_wdata_i  input  LINE_WORDS*32  write data; word i at bits [32*i+31:32*i]
- line_req_be_i  input  LINE_WORDS*4  byte enables; word i at bits [4*i+3:4*i]
- line_rsp_valid_o  output  1  line response valid
- line_rsp_ready_i  input  1  consumer accepts the response
- line_rsp_we_o  output  1  echo of the request's we
- line_rsp_rdata_o  output  LINE_WORDS*32  read data, same packing as wdata
- req  obi_req_if.master  -  OBI request: req, gnt, addr, we, be, wdata
- rsp  obi_rsp_if.slave  -  OBI response: rvalid, rdata

Behaviour:
- Clocking and reset:
  - Single clock clk_i.
  - rst_ni is asynchronous, active-low.
  - On reset: state=IDLE, word index=0, all captured registers=0, line_req_ready_o=0 during reset, line_rsp_valid_o=0, line_rsp_rdata_o=0, req.req=0, req.addr/we/be/wdata=0.
  - Reset mid-operation aborts the line. No response is produced. Any in-flight OBI rvalid after reset release is ignored.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE:
  - line_req_ready_o=1.
  - On valid&ready, capture we, aligned base address, wdata, be. Clear the line buffer to 0. Set index=0. Go to REQ.
- REQ:
  - Drive req.req=1 with:
    - addr = base + 4*index (32-bit, wraps modulo 2^32)
    - we = captured we
    - be = word's be for writes, 4'hF for reads
    - wdata = word's data
  - All of these stay stable until gnt.
  - On gnt go to WAIT. Without gnt, remain in REQ.
- WAIT:
  - req.req=0.
  - On rsp.rvalid:
    - Reads: store rsp.rdata into buffer word[index].
    - Writes: discard rsp.rdata.
  - If index==LINE_WORDS-1, go to RSP. Otherwise index++ and go to REQ.
- RSP:
  - line_rsp_valid_o=1, with rdata=buffer and we_o=captured we.
  - All outputs are held stable until line_rsp_ready_i.
  - On ready go to IDLE.
  - Write responses carry rdata=0.
- Timing with the OBI SRAM (gnt in the same cycle as req, rvalid the next cycle):
  - Each word takes 2 cycles.
  - Acceptance is at cycle 0; line_rsp_valid_o rises at cycle 2*LINE_WORDS+1.
  - line_req_ready_o=0 in REQ, WAIT and RSP. No new request is accepted in the cycle the response is consumed.
- rsp.rvalid in IDLE, REQ or RSP is ignored.
- Index counter is $clog2(LINE_WORDS) bits, minimum 1 bit. LINE_WORDS=1 gives a single transaction.

Optional Feature:
- Macro OBI_LINE_SKIP_EMPTY_EN.
- Defined:
  - During writes, any word whose 4-bit be==0 is skipped. No OBI transaction is issued, and the index advances without spending a cycle in REQ.
  - If all be are zero, the adapter goes from IDLE directly to RSP on the next cycle.
  - Reads are unaffected.
- Undefined: every word is issued, including be==0 (the slave writes nothing but still responds).

Test Plan:
- Read, LINE_WORDS=4, addr=0x104, memory words at 0x100..0x10C = 0xA0,0xA1,0xA2,0xA3 → OBI addrs 0x100,0x104,0x108,0x10C with be=0xF. rdata_o = {0xA3,0xA2,0xA1,0xA0}. line_rsp_valid_o at cycle 9.
- Write, addr=0x200, wdata words 0x11111111..0x44444444, be=16'hF0FF → word2 not written (or skipped with OBI_LINE_SKIP_EMPTY_EN, valid then at cycle 7). Readback shows words 0,1,3 updated, word 2 unchanged. we_o=1, rdata_o=0.
- Backpressure: hold line_rsp_ready_i=0 for 5 cycles → valid/rdata stable for all 5 cycles. line_req_ready_o=0 throughout. Accepted on the first cycle ready=1, and IDLE follows.
- Delayed gnt: slave withholds gnt for 3 cycles on word 1 → addr/be/wdata stable across all stall cycles. Response data still correct.
- Reset mid-line: assert rst_ni low in WAIT of word 2 → all outputs 0 immediately. After release, IDLE with ready=1. A stray rvalid is ignored. The next read completes normally.
- Address wrap: read at 0xFFFFFFF0 → addrs 0xFFFFFFF0..0xFFFFFFFC with no carry into other bits. All-zero-be write with OBI_LINE_SKIP_EMPTY_EN → no req.req pulses, rsp at cycle 1.
